// File: rtl/seg7_display_decoder.sv
// Readback decoder for the dual seven-segment display bus: demuxes tens/ones, decodes
// segments and commits stable digits. Define SEG7_HEX_EN to also decode hex letters A-F.
module seg7_display_decoder #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic       err_clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] valid,
  output logic [1:0] upd,
  output logic       err,
  output logic       stale
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

  logic [7:0]          seg_q;
  logic                smp_vld_q;
  logic                sel_prev_q, sel_prev_d;
  logic [1:0][3:0]     cand_q, cand_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0][3:0]     digit_q, digit_d;
  logic [1:0]          valid_q, valid_d;
  logic [1:0]          upd_q, upd_d;
  logic                err_q, err_d;
  logic [WW-1:0]       wd_q, wd_d;

  logic [4:0]          dec;
  logic                ch;

  // Returns {ok, digit}; ok=0 marks an undecodable pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h00: r = 5'h1F;
`ifdef SEG7_HEX_EN
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
`endif
      default: r = 5'h0F;
    endcase
    return r;
  endfunction

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    valid_d    = valid_q;
    upd_d      = '0;
    err_d      = err_q;
    sel_prev_d = seg_q[7];
    dec        = decode(seg_q[6:0]);
    ch         = seg_q[7];

    if (err_clr)
      err_d = 1'b0;

    // Only the channel named by digit_sel is touched; the other keeps its streak.
    if (smp_vld_q) begin
      if (!dec[4]) begin
        cand_d[ch] = '1;
        cnt_d[ch]  = '0;
        err_d      = 1'b1;
      end else begin
        if (dec[3:0] == cand_q[ch]) begin
          if (cnt_q[ch] != CNT_MAX)
            cnt_d[ch] = cnt_q[ch] + CW'(1);
        end else begin
          cand_d[ch] = dec[3:0];
          cnt_d[ch]  = CW'(1);
        end
        if (cnt_d[ch] == CNT_MAX) begin
          digit_d[ch] = dec[3:0];
          valid_d[ch] = 1'b1;
          upd_d[ch]   = (digit_q[ch] != dec[3:0]);
        end
      end
    end

    if (seg_q[7] != sel_prev_q)
      wd_d = '0;
    else if (wd_q == WD_MAX)
      wd_d = wd_q;
    else
      wd_d = wd_q + WW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '0;
      smp_vld_q  <= 1'b0;
      sel_prev_q <= 1'b0;
      cand_q     <= '1;
      cnt_q      <= '0;
      digit_q    <= '1;
      valid_q    <= '0;
      upd_q      <= '0;
      err_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      seg_q      <= seg_in;
      smp_vld_q  <= 1'b1;
      sel_prev_q <= sel_prev_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
    end
  end

  assign tens  = digit_q[1];
  assign ones  = digit_q[0];
  assign valid = valid_q;
  assign upd   = upd_q;
  assign err   = err_q;
  assign stale = (wd_q == WD_MAX);

endmodule

// File: tb/tb_seg7_display_decoder.sv
// Directed-vector bench for seg7_display_decoder with a run-length reference model
// compared against the DUT on every falling clock edge.
module tb_seg7_display_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       err_clr = 1'b0;
  logic [3:0] tens, ones;
  logic [1:0] valid, upd;
  logic       err, stale;

  int checks = 0;
  int failures = 0;
  int upd_count = 0;

  seg7_display_decoder #(.STABLE_CNT(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .err_clr(err_clr),
    .tens(tens), .ones(ones), .valid(valid), .upd(upd), .err(err), .stale(stale)
  );

  always #5 clk = ~clk;

  logic [6:0] DPAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] HPAT [6]  = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int mdec(input logic [6:0] p);
    int r;
    r = -1;
    if (p == 7'h00) r = 15;
    for (int i = 0; i < 10; i++) if (DPAT[i] == p) r = i;
`ifdef SEG7_HEX_EN
    for (int i = 0; i < 6; i++) if (HPAT[i] == p) r = 10 + i;
`endif
    return r;
  endfunction

  // Reference model: tracks the current run of identical decoded samples per digit.
  int         m_dig [2] = '{15, 15};
  bit         m_val [2] = '{0, 0};
  bit         m_upd [2] = '{0, 0};
  int         run_val [2] = '{-1, -1};
  int         run_len [2] = '{0, 0};
  bit         m_err = 0;
  int         m_wd = 0;
  bit         m_prev = 0;
  logic [7:0] m_pipe = 8'h00;
  bit         m_pv = 0;
  int         mc, md;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_dig = '{15, 15}; m_val = '{0, 0}; m_upd = '{0, 0};
      run_val = '{-1, -1}; run_len = '{0, 0};
      m_err = 0; m_wd = 0; m_prev = 0; m_pipe = 8'h00; m_pv = 0;
    end else begin
      m_upd = '{0, 0};
      if (err_clr) m_err = 0;
      if (m_pv) begin
        mc = int'(m_pipe[7]);
        md = mdec(m_pipe[6:0]);
        if (md < 0) begin
          run_val[mc] = -1; run_len[mc] = 0; m_err = 1;
        end else begin
          if (md == run_val[mc]) run_len[mc]++;
          else begin run_val[mc] = md; run_len[mc] = 1; end
          if (run_len[mc] >= STABLE) begin
            m_upd[mc] = (m_dig[mc] != md);
            m_dig[mc] = md;
            m_val[mc] = 1;
          end
        end
      end
      if (m_pipe[7] != m_prev) m_wd = 0;
      else if (m_wd < TMO) m_wd++;
      m_prev = m_pipe[7];
      m_pipe = seg_in;
      m_pv = 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [13:0] exp_vec;
  initial forever begin
    @(negedge clk);
    exp_vec = {4'(m_dig[1]), 4'(m_dig[0]), m_val[1], m_val[0], m_upd[1], m_upd[0],
               m_err, (m_wd == TMO)};
    check("model{tens,ones,valid,upd,err,stale}",
          32'({tens, ones, valid, upd, err, stale}), 32'(exp_vec));
    if (upd[1]) upd_count++;
    if (upd[0]) upd_count++;
  end

  task automatic step(input logic [7:0] s, input logic c);
    seg_in  = s;
    err_clr = c;
    @(negedge clk);
  endtask

  logic [7:0] seq3 [16] = '{8'h86, 8'h5B, 8'h86, 8'h5B, 8'h86, 8'h5B, 8'h87, 8'h5B,
                            8'h86, 8'h5B, 8'h86, 8'h5B, 8'h86, 8'h5B, 8'h86, 8'h5B};

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", 32'({tens, ones, valid, upd, err, stale}), 32'({8'hFF, 6'b0}));
    rst_n = 1'b1;

    // Alternating digit_sel: tens=1 after the 8th step, ones=2 one step later.
    repeat (3) begin step(8'h86, 0); step(8'h5B, 0); end
    step(8'h86, 0);
    check("t2_tens_not_yet", 32'(tens), 32'hF);
    step(8'h5B, 0);
    check("t2_tens_commit", 32'({tens, upd}), 32'({4'h1, 2'b10}));
    check("t2_ones_not_yet", 32'(ones), 32'hF);
    step(8'h86, 0);
    check("t2_ones_commit", 32'({ones, upd, valid}), 32'({4'h2, 2'b01, 2'b11}));
    upd_count = 0;
    repeat (10) begin step(8'h5B, 0); step(8'h86, 0); end
    check("t2_no_more_upd", 32'(upd_count), 32'd0);

    // Reset with streaks in progress.
    step(8'hFF, 0); step(8'h66, 0); step(8'hFF, 0);
    #2 rst_n = 1'b0;
    #1 check("t1_async_reset", 32'({tens, ones, valid, upd, err, stale}), 32'({8'hFF, 6'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // A lone 07 breaks the tens streak; interleaved ones samples do not.
    for (int i = 0; i < 16; i++) begin
      step(seq3[i], 0);
      if (i == 8)  check("t3_ones_commit", 32'(ones), 32'h2);
      if (i == 14) check("t3_tens_not_yet", 32'(tens), 32'hF);
      if (i == 15) check("t3_tens_commit", 32'(tens), 32'h1);
    end

    // Sticky error with set-wins priority.
    step(8'h01, 0);
    step(8'h01, 1);
    check("t4_err_set_wins", 32'({err, ones}), 32'({1'b1, 4'h2}));
    step(8'h5B, 1);
    check("t4_err_still", 32'(err), 32'h1);
    step(8'h5B, 0);
    step(8'h5B, 1);
    check("t4_err_cleared", 32'(err), 32'h0);

    // Watchdog with digit_sel held low.
    step(8'h86, 0);
    repeat (17) step(8'h5B, 0);
    check("t5_stale_pre", 32'(stale), 32'h0);
    step(8'h5B, 0);
    check("t5_stale_set", 32'({stale, tens, ones, valid}), 32'({1'b1, 4'h1, 4'h2, 2'b11}));
    step(8'h86, 0);
    check("t5_stale_hold", 32'(stale), 32'h1);
    step(8'h5B, 0);
    check("t5_stale_clear", 32'({stale, tens, ones, valid}), 32'({1'b0, 4'h1, 4'h2, 2'b11}));

    // Hex letter A on the tens digit.
    repeat (5) step(8'hF7, 0);
`ifdef SEG7_HEX_EN
    check("t6_hex_commit", 32'({tens, upd, err}), 32'({4'hA, 2'b10, 1'b0}));
`else
    check("t6_hex_invalid", 32'({tens, err}), 32'({4'h1, 1'b1}));
`endif
    step(8'h5B, 1);

    // Sweep every decimal pattern, blank and the hex patterns on ones.
    for (int d = 0; d < 10; d++) begin
      repeat (5) step({1'b0, DPAT[d]}, 0);
      check("sweep_ones", 32'(ones), 32'(d));
      repeat (5) step({1'b1, DPAT[9 - d]}, 0);
      check("sweep_tens", 32'(tens), 32'(9 - d));
    end
    repeat (5) step(8'h00, 0);
    check("blank_ones", 32'(ones), 32'hF);
    for (int h = 0; h < 6; h++) repeat (5) step({1'b0, HPAT[h]}, 0);
    repeat (3) step(8'h80, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
